// File: rtl/conv1_pool_if.sv
// Pixel stream bundle between conv1 and the conv2 input buffer.
// The pool block is the slave (consumes conv1 pixels, drives the pooled stream).
interface conv1_pool_if #(
    parameter int DATA_BITS = 12
);
    logic                 valid_in;
    logic [DATA_BITS-1:0] data_in;
    logic                 valid_out;
    logic [DATA_BITS-1:0] data_out;
    logic                 frame_done;

    modport master (
        output valid_in, data_in,
        input  valid_out, data_out, frame_done
    );

    modport slave (
        input  valid_in, data_in,
        output valid_out, data_out, frame_done
    );
endinterface

// File: rtl/conv1_pool.sv
// Streaming 2x2/stride-2 signed max-pool over the conv1 feature map, half-row line buffer.
// Define CONV1_POOL_RELU_EN to clamp negative input samples to zero before pooling.
module conv1_pool #(
    parameter int IN_WIDTH  = 24,
    parameter int IN_HEIGHT = 24,
    parameter int DATA_BITS = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    conv1_pool_if.slave  io
);
    localparam int CW = $clog2(IN_WIDTH);
    localparam int RW = $clog2(IN_HEIGHT);
    localparam int HW = IN_WIDTH / 2;
    localparam int LW = (HW > 1) ? $clog2(HW) : 1;

    typedef logic signed [DATA_BITS-1:0] sample_t;

    // Ties keep the first operand.
    function automatic sample_t smax(input sample_t a, input sample_t b);
        return (b > a) ? b : a;
    endfunction

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    sample_t       h_q, h_d;
    sample_t       data_out_q, data_out_d;
    logic          valid_out_q, valid_out_d;
    logic          frame_done_q, frame_done_d;

    sample_t       line_buf_q [HW];
    logic          lb_we;
    logic [LW-1:0] lb_idx;
    sample_t       x_act, hmax, lb_rd;
    logic          col_last, row_last;

    assign col_last = (col_q == CW'(IN_WIDTH - 1));
    assign row_last = (row_q == RW'(IN_HEIGHT - 1));
    assign lb_idx   = LW'(col_q >> 1);
    assign lb_rd    = line_buf_q[lb_idx];
    assign hmax     = smax(h_q, x_act);

    always_comb begin
        x_act = sample_t'(io.data_in);
`ifdef CONV1_POOL_RELU_EN
        if (x_act < 0) x_act = '0;
`endif
    end

    always_comb begin
        col_d        = col_q;
        row_d        = row_q;
        h_d          = h_q;
        data_out_d   = data_out_q;
        valid_out_d  = 1'b0;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;
        if (io.valid_in) begin
            if (!col_q[0]) begin
                h_d = x_act;
            end else if (!row_q[0]) begin
                lb_we = rst_n;
            end else begin
                // Odd row completes the 2x2 window: combine with the stored upper pair.
                data_out_d   = smax(lb_rd, hmax);
                valid_out_d  = 1'b1;
                frame_done_d = col_last && row_last;
            end
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            h_q          <= '0;
            data_out_q   <= '0;
            valid_out_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            h_q          <= h_d;
            data_out_q   <= data_out_d;
            valid_out_q  <= valid_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Written on even rows, read on odd rows, so no reset is needed.
    always_ff @(posedge clk) begin
        if (lb_we) line_buf_q[lb_idx] <= hmax;
    end

    assign io.data_out   = data_out_q;
    assign io.valid_out  = valid_out_q;
    assign io.frame_done = frame_done_q;
endmodule

// File: tb/tb_conv1_pool.sv
// Randomized scoreboard bench for conv1_pool: driver pushes expected pooled pixels
// from a frame-array model, a monitor pops and compares on every valid_out.
module tb_conv1_pool;
    localparam int W  = 24;
    localparam int H  = 24;
    localparam int DB = 12;
    localparam int NOUT = (W / 2) * (H / 2);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv1_pool_if #(.DATA_BITS(DB)) io ();
    conv1_pool #(.IN_WIDTH(W), .IN_HEIGHT(H), .DATA_BITS(DB)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .io   (io)
    );

    typedef struct {
        logic [DB-1:0] data;
        logic          fd;
        int            cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0, failures = 0;
    int   cyc = 0, n_out = 0, n_fd = 0, exp_out = 0, exp_fd = 0;
    int   pix[H][W];
    int   m_row = 0, m_col = 0;
    int   gap_pct = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int act(input logic [DB-1:0] v);
        int s;
        s = int'($signed(v));
`ifdef CONV1_POOL_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, want);
        end
    endtask

    // One accepted pixel, preceded by random idle cycles when gap_pct > 0.
    task automatic send(input logic [DB-1:0] v);
        exp_t e;
        int   m;
        while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
            @(negedge clk);
            io.valid_in = 1'b0;
            io.data_in  = DB'($urandom);
        end
        @(negedge clk);
        io.valid_in = 1'b1;
        io.data_in  = v;
        pix[m_row][m_col] = act(v);
        if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
            m = pix[m_row][m_col];
            for (int dr = 0; dr < 2; dr++)
                for (int dc = 0; dc < 2; dc++)
                    if (pix[m_row-dr][m_col-dc] > m) m = pix[m_row-dr][m_col-dc];
            e.data = DB'(m);
            e.fd   = (m_row == H - 1) && (m_col == W - 1);
            e.cyc  = cyc + 1;
            sbq.push_back(e);
            exp_out++;
            if (e.fd) exp_fd++;
        end
        if (m_col == W - 1) begin
            m_col = 0;
            m_row = (m_row == H - 1) ? 0 : m_row + 1;
        end else begin
            m_col++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            io.valid_in = 1'b0;
        end
    endtask

    task automatic send_ramp();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send(DB'(r * W + c));
    endtask

    task automatic send_random();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send(DB'($urandom));
    endtask

    // Monitor: output-side checking, independent of the driver.
    always @(posedge clk) begin
        #1;
        if (io.valid_out) begin
            n_out++;
            if (io.frame_done) n_fd++;
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_out got data=%0h fd=%b expected no output", io.data_out, io.frame_done);
            end else begin
                mon_e = sbq.pop_front();
                if (io.data_out !== mon_e.data || io.frame_done !== mon_e.fd || cyc != mon_e.cyc) begin
                    failures++;
                    $display("FAIL pooled_out got data=%0h fd=%b cyc=%0d expected data=%0h fd=%b cyc=%0d",
                             io.data_out, io.frame_done, cyc, mon_e.data, mon_e.fd, mon_e.cyc);
                end
            end
        end else if (io.frame_done) begin
            checks++;
            failures++;
            $display("FAIL frame_done_alone got fd=1 expected fd=0 without valid_out");
        end
    end

    initial begin
        io.valid_in = 1'b0;
        io.data_in  = '0;
        rst_n       = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid_out", 32'(io.valid_out), 32'd0);
        chk("rst_data_out", 32'(io.data_out), 32'd0);
        chk("rst_frame_done", 32'(io.frame_done), 32'd0);
        rst_n = 1'b1;

        send_ramp();
        idle(3);
        for (int i = 0; i < H * W; i++) send(DB'(-5));
        idle(2);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                send((r == 7 && c == 10) ? DB'(100) : DB'(0));
        idle(2);

        gap_pct = 60;
        send_ramp();
        gap_pct = 0;

        send_random();
        send_random();
        gap_pct = 40;
        send_random();
        gap_pct = 0;
        idle(4);

        // Abort a ramp frame at pixel (13,5); valid_in on the reset edge must be ignored.
        for (int i = 0; i < 13 * W + 5; i++) send(DB'(i));
        @(negedge clk);
        rst_n       = 1'b0;
        io.valid_in = 1'b1;
        io.data_in  = DB'($urandom);
        m_row = 0;
        m_col = 0;
        @(negedge clk);
        chk("midrst_valid_out", 32'(io.valid_out), 32'd0);
        chk("midrst_data_out", 32'(io.data_out), 32'd0);
        chk("midrst_sb_empty", 32'(sbq.size()), 32'd0);
        rst_n       = 1'b1;
        io.valid_in = 1'b0;
        send_ramp();
        idle(5);

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        chk("out_count", 32'(n_out), 32'(8 * NOUT + 74));
        chk("out_count_model", 32'(n_out), 32'(exp_out));
        chk("frame_done_count", 32'(n_fd), 32'd8);
        chk("frame_done_model", 32'(n_fd), 32'(exp_fd));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end
endmodule
